// File: rtl/wb_mem_bist_master.sv
// Wishbone classic initiator that writes a seeded pattern to every SRAM word,
// reads it all back and reports pass/fail, error count and first failing word.
module wb_mem_bist_master #(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int unsigned WORDS     = 256,
    parameter logic [3:0]  TIMEOUT   = 4'd15
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [31:0] seed_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [8:0]  err_count_o,
    output logic [7:0]  fail_addr_o,
    output logic [31:0] fail_data_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_GAP = 3'd2,
        RD_REQ = 3'd3,
        RD_GAP = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [7:0] LAST = 8'(WORDS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  idx;
    logic [7:0]  idx_inc;
    logic [31:0] seed;
    logic [3:0]  tmo_cnt;
    logic        req_active;
    logic        tmo_hit;
    logic        last;

    function automatic logic [31:0] pattern(input logic [31:0] s, input logic [7:0] i);
        return s ^ {4{i}};
    endfunction

    function automatic logic [31:0] word_addr(input logic [7:0] i);
        return ADDR_BASE + {22'd0, i, 2'b00};
    endfunction

    // Classic handshake: a request is stb=1 with stable adr/dat/we/sel; it
    // completes on the first edge where ack=1 is sampled. Ack while stb=0 is ignored.
    assign req_active = (state == WR_REQ) || (state == RD_REQ);
    assign tmo_hit    = req_active && !wbm_ack_i && (tmo_cnt == TIMEOUT - 4'd1);
    assign last       = (idx == LAST);
    assign idx_inc    = idx + 8'd1;

    assign wbm_cyc_o = req_active;
    assign wbm_stb_o = req_active;
    assign wbm_sel_o = req_active ? 4'hF : 4'h0;
    assign busy_o    = (state != IDLE) && (state != DONE);
    assign state_o   = state;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = WR_REQ;
            WR_REQ: begin
                if (wbm_ack_i)    state_nxt = WR_GAP;
                else if (tmo_hit) state_nxt = DONE;
            end
            WR_GAP:  state_nxt = last ? RD_REQ : WR_REQ;
            RD_REQ: begin
                if (wbm_ack_i)    state_nxt = RD_GAP;
                else if (tmo_hit) state_nxt = DONE;
            end
            RD_GAP:  state_nxt = last ? DONE : RD_REQ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            seed        <= '0;
            idx         <= '0;
            tmo_cnt     <= '0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
            err_count_o <= '0;
            fail_addr_o <= '0;
            fail_data_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        seed        <= seed_i;
                        idx         <= '0;
                        tmo_cnt     <= '0;
                        wbm_we_o    <= 1'b1;
                        wbm_adr_o   <= word_addr(8'd0);
                        wbm_dat_o   <= pattern(seed_i, 8'd0);
                        done_o      <= 1'b0;
                        pass_o      <= 1'b0;
                        timeout_o   <= 1'b0;
                        err_count_o <= '0;
                        fail_addr_o <= '0;
                        fail_data_o <= '0;
                    end
                end
                WR_REQ, RD_REQ: begin
                    if (wbm_ack_i) begin
                        if (state == RD_REQ && wbm_dat_i != pattern(seed, idx)) begin
                            if (err_count_o != '1) err_count_o <= err_count_o + 9'd1;
                            // A zero count means this is the first mismatch of the run
                            if (err_count_o == '0) begin
                                fail_addr_o <= idx;
                                fail_data_o <= wbm_dat_i;
                            end
                        end
                    end else if (tmo_hit) begin
                        timeout_o <= 1'b1;
                        done_o    <= 1'b1;
                        pass_o    <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end
                WR_GAP: begin
                    tmo_cnt <= '0;
                    if (last) begin
                        idx       <= '0;
                        wbm_we_o  <= 1'b0;
                        wbm_adr_o <= word_addr(8'd0);
                    end else begin
                        idx       <= idx_inc;
                        wbm_adr_o <= word_addr(idx_inc);
                        wbm_dat_o <= pattern(seed, idx_inc);
                    end
                end
                RD_GAP: begin
                    tmo_cnt <= '0;
                    if (last) begin
                        done_o <= 1'b1;
                        pass_o <= (err_count_o == '0) && !timeout_o;
                    end else begin
                        idx       <= idx_inc;
                        wbm_adr_o <= word_addr(idx_inc);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_bist_master.sv
// Directed bench for wb_mem_bist_master: SRAM slave model with programmable ack
// latency, read bit-flips and a stalled word, driven from a table of test vectors.
module tb_wb_mem_bist_master;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int WORDS = 256;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start_i;
    logic [31:0] seed_i;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;
    logic        busy_o, done_o, pass_o, timeout_o;
    logic [8:0]  err_count_o;
    logic [7:0]  fail_addr_o;
    logic [31:0] fail_data_o;
    logic [2:0]  state_o;

    wb_mem_bist_master dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .start_i     (start_i),
        .seed_i      (seed_i),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .timeout_o   (timeout_o),
        .err_count_o (err_count_o),
        .fail_addr_o (fail_addr_o),
        .fail_data_o (fail_data_o),
        .state_o     (state_o)
    );

    // clock
    always #5 wb_clk_i = ~wb_clk_i;

    // SRAM slave model
    logic [31:0] mem [WORDS];
    logic        flip [WORDS];
    int          lat_mode = 1;
    int          stall_word = -1;
    int          slv_cnt = 0;
    int          cur_lat = 1;
    logic [7:0]  word;

    assign word      = wbm_adr_o[9:2];
    assign wbm_ack_i = wbm_stb_o && !(wbm_we_o && stall_word == int'(word)) && (slv_cnt == cur_lat);
    assign wbm_dat_i = mem[word] ^ {31'd0, flip[word]};

    always @(posedge wb_clk_i) begin
        if (!wbm_stb_o || wbm_ack_i) begin
            slv_cnt <= 0;
            cur_lat <= (lat_mode < 0) ? int'($urandom_range(0, 6)) : lat_mode;
            if (wbm_stb_o && wbm_we_o) mem[word] <= wbm_dat_o;
        end else begin
            slv_cnt <= slv_cnt + 1;
        end
    end

    // scoreboard
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] seed;
        int          lat;       // -1: random 0..6 per access
        int          flip_a;
        int          flip_b;
        logic        flip_all;
        int          stall;     // write to this word is never acked
        int          poke;      // cycle of an extra start pulse, 0 = none
        int          exp_cyc;   // cycle in which done_o first reads 1, 0 = unchecked
        int          exp_run;   // longest stb run, 0 = unchecked
        logic        exp_pass;
        logic        exp_tmo;
        logic [8:0]  exp_err;
        logic [7:0]  exp_addr;
        logic [31:0] exp_data;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic check_all_zero(input string tag);
        check({tag, ".cyc"}, 64'(wbm_cyc_o), 64'(0));
        check({tag, ".stb"}, 64'(wbm_stb_o), 64'(0));
        check({tag, ".we"}, 64'(wbm_we_o), 64'(0));
        check({tag, ".sel"}, 64'(wbm_sel_o), 64'(0));
        check({tag, ".adr"}, 64'(wbm_adr_o), 64'(0));
        check({tag, ".dat"}, 64'(wbm_dat_o), 64'(0));
        check({tag, ".busy"}, 64'(busy_o), 64'(0));
        check({tag, ".done"}, 64'(done_o), 64'(0));
        check({tag, ".pass"}, 64'(pass_o), 64'(0));
        check({tag, ".timeout"}, 64'(timeout_o), 64'(0));
        check({tag, ".err"}, 64'(err_count_o), 64'(0));
        check({tag, ".fail_addr"}, 64'(fail_addr_o), 64'(0));
        check({tag, ".fail_data"}, 64'(fail_data_o), 64'(0));
        check({tag, ".state"}, 64'(state_o), 64'(0));
    endtask

    task automatic run_vec(input vec_t v);
        int          cyc, run, max_run, n_wr, n_rd, viol, done_cyc;
        logic        stb, hs, prev_stb, prev_hs, prev_we;
        logic [31:0] prev_adr, prev_dat, exp_d;
        exp_q.delete();
        for (int i = 0; i < WORDS; i++) begin
            exp_q.push_back(v.seed ^ {4{8'(i)}});
            flip[i] = v.flip_all || (i == v.flip_a) || (i == v.flip_b);
        end
        stall_word = v.stall;
        lat_mode   = v.lat;
        @(negedge wb_clk_i);
        seed_i  = v.seed;
        start_i = 1'b1;
        cyc = 0; run = 0; max_run = 0; n_wr = 0; n_rd = 0; viol = 0; done_cyc = 0;
        prev_stb = 1'b0; prev_hs = 1'b0; prev_we = 1'b0; prev_adr = '0; prev_dat = '0;
        while (cyc < 20000 && done_cyc == 0) begin
            @(negedge wb_clk_i);
            cyc++;
            start_i = (cyc == v.poke);
            if (cyc == v.poke) seed_i = 32'hDEAD_BEEF;
            stb = wbm_stb_o;
            hs  = stb && wbm_ack_i;
            if (cyc == 1) begin
                check({v.name, ".clr_done"}, 64'(done_o), 64'(0));
                check({v.name, ".clr_err"}, 64'(err_count_o), 64'(0));
                check({v.name, ".clr_fail_addr"}, 64'(fail_addr_o), 64'(0));
                check({v.name, ".clr_fail_data"}, 64'(fail_data_o), 64'(0));
                check({v.name, ".first_stb"}, 64'({stb, busy_o}), 64'(2'b11));
            end
            if (wbm_cyc_o !== stb) viol++;
            if (wbm_sel_o !== (stb ? 4'hF : 4'h0)) viol++;
            if (stb && !busy_o) viol++;
            if (stb && prev_stb && !prev_hs &&
                ({wbm_adr_o, wbm_dat_o, wbm_we_o} !== {prev_adr, prev_dat, prev_we})) viol++;
            if (prev_hs && stb) viol++;
            if (busy_o && !stb && !prev_hs) viol++;
            run = stb ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (hs && wbm_we_o) begin
                if (exp_q.size() == 0) viol++;
                else begin
                    exp_d = exp_q.pop_front();
                    if (wbm_dat_o !== exp_d || wbm_adr_o !== BASE + 32'(n_wr * 4)) viol++;
                end
                n_wr++;
            end
            if (hs && !wbm_we_o) begin
                if (wbm_adr_o !== BASE + 32'(n_rd * 4)) viol++;
                n_rd++;
            end
            prev_stb = stb; prev_hs = hs; prev_we = wbm_we_o;
            prev_adr = wbm_adr_o; prev_dat = wbm_dat_o;
            if (done_o) done_cyc = cyc;
        end
        check({v.name, ".done_reached"}, 64'(done_cyc != 0), 64'(1));
        if (v.exp_cyc != 0) check({v.name, ".done_cycle"}, 64'(done_cyc), 64'(v.exp_cyc));
        if (v.exp_run != 0) check({v.name, ".stb_run"}, 64'(max_run), 64'(v.exp_run));
        check({v.name, ".done_state"}, 64'(state_o), 64'(5));
        check({v.name, ".busy"}, 64'(busy_o), 64'(0));
        check({v.name, ".pass"}, 64'(pass_o), 64'(v.exp_pass));
        check({v.name, ".timeout"}, 64'(timeout_o), 64'(v.exp_tmo));
        check({v.name, ".err"}, 64'(err_count_o), 64'(v.exp_err));
        check({v.name, ".fail_addr"}, 64'(fail_addr_o), 64'(v.exp_addr));
        check({v.name, ".fail_data"}, 64'(fail_data_o), 64'(v.exp_data));
        check({v.name, ".writes"}, 64'(n_wr), 64'(v.exp_wr));
        check({v.name, ".reads"}, 64'(n_rd), 64'(v.exp_rd));
        check({v.name, ".protocol"}, 64'(viol), 64'(0));
        @(negedge wb_clk_i);
        start_i = 1'b0;
        check({v.name, ".idle_after"}, 64'(state_o), 64'(0));
        check({v.name, ".done_sticky"}, 64'({done_o, pass_o, wbm_stb_o}), 64'({1'b1, v.exp_pass, 1'b0}));
    endtask

    initial begin
        logic found;
        //          name          seed           lat fa   fb   all   stall poke  cyc   run pass tmo err     addr   data
        vecs[0] = '{"clean_l1",   32'hA5A5_0000, 1,  -1,  -1,  1'b0, -1,   0,    1537, 2,  1'b1, 1'b0, 9'd0,   8'd0,   32'h0000_0000, 256, 256};
        vecs[1] = '{"flip_5_200", 32'hA5A5_0000, 1,  5,   200, 1'b0, -1,   0,    1537, 2,  1'b0, 1'b0, 9'd2,   8'd5,   32'hA0A0_0504, 256, 256};
        vecs[2] = '{"stall_w3",   32'hA5A5_0000, 1,  -1,  -1,  1'b0, 3,    0,    25,   15, 1'b0, 1'b1, 9'd0,   8'd0,   32'h0000_0000, 3,   0};
        vecs[3] = '{"rand_lat",   32'h1234_5678, -1, -1,  -1,  1'b0, -1,   0,    0,    0,  1'b1, 1'b0, 9'd0,   8'd0,   32'h0000_0000, 256, 256};
        vecs[4] = '{"l0_allflip", 32'h0F0F_0F0F, 0,  -1,  -1,  1'b1, -1,   0,    1025, 1,  1'b0, 1'b0, 9'd256, 8'd0,   32'h0F0F_0F0E, 256, 256};
        vecs[5] = '{"l2_edges",   32'h0000_0000, 2,  0,   255, 1'b0, -1,   0,    2049, 3,  1'b0, 1'b0, 9'd2,   8'd0,   32'h0000_0001, 256, 256};
        vecs[6] = '{"busy_start", 32'hA5A5_0000, 1,  -1,  -1,  1'b0, -1,   500,  1537, 2,  1'b1, 1'b0, 9'd0,   8'd0,   32'h0000_0000, 256, 256};
        vecs[7] = '{"done_start", 32'hC3C3_3C3C, 0,  255, -1,  1'b0, -1,   1025, 1025, 1,  1'b0, 1'b0, 9'd1,   8'd255, 32'h3C3C_C3C2, 256, 256};
        for (int i = 0; i < WORDS; i++) flip[i] = 1'b0;

        // reset, with start held high alongside it
        wb_rst_i = 1'b1;
        start_i  = 1'b1;
        seed_i   = 32'hFFFF_FFFF;
        repeat (3) @(negedge wb_clk_i);
        check_all_zero("reset");
        wb_rst_i = 1'b0;
        start_i  = 1'b0;
        @(negedge wb_clk_i);
        check_all_zero("post_reset_idle");

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // reset while the 100th write is on the bus
        lat_mode   = 1;
        stall_word = -1;
        for (int i = 0; i < WORDS; i++) flip[i] = 1'b0;
        @(negedge wb_clk_i);
        seed_i  = 32'h5A5A_5A5A;
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            if (wbm_stb_o && wbm_we_o && wbm_adr_o == BASE + 32'(99 * 4)) found = 1'b1;
            else @(negedge wb_clk_i);
        end
        check("mid_reset.reached_w99", 64'(found), 64'(1));
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        check_all_zero("mid_reset");
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_mem_bist_master.md
# wb_mem_bist_master

Wishbone classic initiator that runs a write-then-readback self-test over the 256-word user SRAM. On `start_i` it writes a seeded pattern to every word, reads every word back, compares, and reports pass/fail, an error count and the first failing location. It sits in the user project wrapper and drives the same Wishbone slave port that the management SoC otherwise drives, so the SRAM can be verified on silicon without firmware.

## Interface
- `ADDR_BASE`, 32'h3000_0000: byte address of word 0.
- `WORDS`, 256: words tested; must be a power of two, at most 256.
- `TIMEOUT`, 15: maximum wait, in cycles, for `ack` after `stb` is raised; 4-bit counter.

- `wb_clk_i`  in  1  the only clock.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  one-cycle start pulse; ignored while `busy_o`=1.
- `seed_i`  in  32  pattern seed; sampled on the accepted start.
- `wbm_cyc_o`  out  1  bus cycle.
- `wbm_stb_o`  out  1  strobe.
- `wbm_we_o`  out  1  1=write, 0=read.
- `wbm_sel_o`  out  4  byte enables; always 4'hF while `stb`=1, else 0.
- `wbm_adr_o`  out  32  `ADDR_BASE + {i,2'b00}`.
- `wbm_dat_o`  out  32  write data.
- `wbm_dat_i`  in  32  read data.
- `wbm_ack_i`  in  1  slave acknowledge.
- `busy_o`  out  1  test running.
- `done_o`  out  1  test finished; sticky until the next accepted start or reset.
- `pass_o`  out  1  valid when `done_o`=1; 1 = no errors and no timeout.
- `timeout_o`  out  1  test aborted on an ack timeout.
- `err_count_o`  out  9  mismatching reads; saturates at 511.
- `fail_addr_o`  out  8  word index of the first mismatch.
- `fail_data_o`  out  32  data read at the first mismatch.

## Operation
- States: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
- IDLE: `start_i`=1 does the following:
  - latches `seed_i`;
  - clears `err_count_o`, `fail_*`, `done_o`, `pass_o` and `timeout_o`;
  - sets i=0 and enters WR_REQ.
- Pattern: P(i) = seed XOR {4{i[7:0]}}.
- WR_REQ: drives `cyc`=`stb`=`we`=1, `sel`=F, address for i and `dat_o`=P(i).
  - On `ack`, goes to WR_GAP.
- WR_GAP: drives `cyc`=`stb`=0 for exactly one cycle.
  - If i=WORDS-1, sets i=0 and enters RD_REQ.
  - Otherwise increments i and returns to WR_REQ.
- RD_REQ: as WR_REQ but with `we`=0; `dat_o` holds its last value.
  - On `ack`, compares `wbm_dat_i` with P(i).
  - On a mismatch, `err_count` increments (saturating). If this is the first mismatch, it also captures `fail_addr_o`=i and `fail_data_o`=`wbm_dat_i`.
- RD_GAP: one idle cycle.
  - If i=WORDS-1, enters DONE.
  - Otherwise increments i and returns to RD_REQ.
- Timeout: a counter clears on entry to a *_REQ state and increments each cycle without `ack`.
  - When it reaches TIMEOUT without `ack`: drops `cyc`/`stb` the next cycle, sets `timeout_o`=1 and enters DONE.
- DONE: sets `done_o`=1, `busy_o`=0 and `pass_o` = (`err_count`==0 && !`timeout_o`), then returns to IDLE the next cycle.
  - `done_o`, `pass_o` and the result registers hold until the next start.
- `busy_o`=1 in every state except IDLE and DONE.
- An `ack` received while `stb`=0 is ignored.

## Timing
- Reset values:
  - all `wbm_*` outputs are 0;
  - `busy_o`, `done_o`, `pass_o` and `timeout_o` are 0;
  - `err_count_o`, `fail_addr_o` and `fail_data_o` are 0;
  - the state is IDLE.
- Start latency: start sampled at edge E puts `stb`=1 in the cycle after E.
- Request timing: `stb` rises in cycle N and `ack` is sampled high at the edge closing cycle N+L (L≥0). Then:
  - `stb`=0 in cycle N+L+1 (the gap cycle);
  - the next `stb` rises in cycle N+L+2.
- Addresses, data, `we` and `sel` are registered and stable for the whole time `stb`=1.
- Total duration with a fixed-latency slave (L cycles): 2·WORDS·(L+2) cycles from the first `stb` to the last gap, then one DONE cycle.
  - Example: WORDS=256, L=1 gives 1536 cycles.
- Reset during a test: the next edge forces `cyc`/`stb` to 0 and the FSM to IDLE, and clears every result. No partial result is reported.
- Start and reset in the same cycle: reset wins.
- A start in the same cycle as DONE is ignored; the block accepts a new start from IDLE only.

## Test plan
- Fault-free SRAM model with 1-cycle ack, seed=32'hA5A5_0000, start pulse:
  - 256 writes at 3000_0000..3000_03FC, then 256 reads;
  - `done_o`=1 after 1537 cycles;
  - `pass_o`=1 and `err_count_o`=0.
- Model flips bit 0 on read of words 5 and 200:
  - `pass_o`=0 and `err_count_o`=2;
  - `fail_addr_o`=5;
  - `fail_data_o`=P(5)^1 = 32'hA0A0_0505^1.
- Slave never acks the write to word 3:
  - `cyc` drops after 15 waiting cycles;
  - `timeout_o`=1, `pass_o`=0, `done_o`=1;
  - no read phase occurs.
- Random ack latency 0–6 per access: every `stb` is held until `ack`, there is exactly one gap cycle, and `pass_o`=1.
- Assert `wb_rst_i` at the 100th write: the next cycle has all outputs 0 and the FSM in IDLE. A new start then completes with `pass_o`=1.
- Start pulses during `busy_o` are ignored and the test completes unchanged; a start while `done_o`=1 clears the results and reruns.
